// File: rtl/draw_arbiter_if.sv
// Bundle of the draw_arbiter control, source-pixel and VGA-stream signals.
// The slave modport is the arbiter's view and the master modport is the environment's view.
interface draw_arbiter_if;
    logic        start;

    logic        bg_draw;
    logic        link_draw;
    logic        enemy_draw;

    logic [8:0]  bg_x;
    logic [8:0]  link_x;
    logic [8:0]  enemy_x;
    logic [7:0]  bg_y;
    logic [7:0]  link_y;
    logic [7:0]  enemy_y;
    logic [5:0]  bg_colour;
    logic [5:0]  link_colour;
    logic [5:0]  enemy_colour;
    logic        bg_write;
    logic        link_write;
    logic        enemy_write;
    logic        bg_done;
    logic        link_done;
    logic        enemy_done;

    logic [8:0]  vga_x;
    logic [7:0]  vga_y;
    logic [5:0]  vga_colour;
    logic        vga_write;

    logic        busy;
    logic        frame_done;
    logic        timeout_err;
    logic [16:0] pixel_count;

    modport slave (
        input  start,
        output bg_draw, link_draw, enemy_draw,
        input  bg_x, link_x, enemy_x,
        input  bg_y, link_y, enemy_y,
        input  bg_colour, link_colour, enemy_colour,
        input  bg_write, link_write, enemy_write,
        input  bg_done, link_done, enemy_done,
        output vga_x, vga_y, vga_colour, vga_write,
        output busy, frame_done, timeout_err, pixel_count
    );

    modport master (
        output start,
        input  bg_draw, link_draw, enemy_draw,
        output bg_x, link_x, enemy_x,
        output bg_y, link_y, enemy_y,
        output bg_colour, link_colour, enemy_colour,
        output bg_write, link_write, enemy_write,
        output bg_done, link_done, enemy_done,
        input  vga_x, vga_y, vga_colour, vga_write,
        input  busy, frame_done, timeout_err, pixel_count
    );
endinterface

// File: rtl/draw_arbiter.sv
// Sequences three pixel sources (background, link, enemy) onto one VGA pixel stream.
// Each phase is bounded by a watchdog, and off-screen pixels are dropped before they reach the VGA.
module draw_arbiter #(
    parameter logic [11:0] TIMEOUT = 12'd2047,
    parameter logic [8:0]  X_MAX   = 9'd319,
    parameter logic [7:0]  Y_MAX   = 8'd239
) (
    input  logic            clock,
    input  logic            resetn,
    draw_arbiter_if.slave   bus
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_BG    = 3'd1,
        S_GAP1  = 3'd2,
        S_LINK  = 3'd3,
        S_GAP2  = 3'd4,
        S_ENEMY = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    state_t      state_q, state_d;
    logic [11:0] cnt_q, cnt_d;
    logic        timeout_err_q, timeout_err_d;
    logic [16:0] pixel_count_q, pixel_count_d;
    logic [8:0]  vga_x_q, vga_x_d;
    logic [7:0]  vga_y_q, vga_y_d;
    logic [5:0]  vga_colour_q, vga_colour_d;
    logic        vga_write_q, vga_write_d;

    logic        in_phase_s;
    logic        start_frame_s;
    logic        timeout_hit_s;
    logic        pix_ok_s;
    logic [8:0]  src_x_s;
    logic [7:0]  src_y_s;
    logic [5:0]  src_colour_s;
    logic        src_write_s;
    logic        src_done_s;

    // Route the source owning the current phase; other sources are never looked at.
    always_comb begin
        in_phase_s   = 1'b0;
        src_x_s      = 9'd0;
        src_y_s      = 8'd0;
        src_colour_s = 6'd0;
        src_write_s  = 1'b0;
        src_done_s   = 1'b0;
        case (state_q)
            S_BG: begin
                in_phase_s   = 1'b1;
                src_x_s      = bus.bg_x;
                src_y_s      = bus.bg_y;
                src_colour_s = bus.bg_colour;
                src_write_s  = bus.bg_write;
                src_done_s   = bus.bg_done;
            end
            S_LINK: begin
                in_phase_s   = 1'b1;
                src_x_s      = bus.link_x;
                src_y_s      = bus.link_y;
                src_colour_s = bus.link_colour;
                src_write_s  = bus.link_write;
                src_done_s   = bus.link_done;
            end
            S_ENEMY: begin
                in_phase_s   = 1'b1;
                src_x_s      = bus.enemy_x;
                src_y_s      = bus.enemy_y;
                src_colour_s = bus.enemy_colour;
                src_write_s  = bus.enemy_write;
                src_done_s   = bus.enemy_done;
            end
            default: begin
                in_phase_s   = 1'b0;
                src_x_s      = 9'd0;
                src_y_s      = 8'd0;
                src_colour_s = 6'd0;
                src_write_s  = 1'b0;
                src_done_s   = 1'b0;
            end
        endcase
    end

    // Qualify the phase events; done wins over a coincident timeout.
    always_comb begin
        start_frame_s = (state_q == S_IDLE) && bus.start;
        timeout_hit_s = in_phase_s && !src_done_s && ((cnt_q + 12'd1) == TIMEOUT);
        pix_ok_s      = in_phase_s && src_write_s && (src_x_s <= X_MAX) && (src_y_s <= Y_MAX);
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_BG;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_BG: begin
                if (src_done_s || timeout_hit_s) begin
                    state_d = S_GAP1;
                end else begin
                    state_d = S_BG;
                end
            end
            S_GAP1:  state_d = S_LINK;
            S_LINK: begin
                if (src_done_s || timeout_hit_s) begin
                    state_d = S_GAP2;
                end else begin
                    state_d = S_LINK;
                end
            end
            S_GAP2:  state_d = S_ENEMY;
            S_ENEMY: begin
                if (src_done_s || timeout_hit_s) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_ENEMY;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath next values: phase counter restarts on any state change, stream holds outside phases.
    always_comb begin
        if (in_phase_s && (state_d == state_q)) begin
            cnt_d = cnt_q + 12'd1;
        end else begin
            cnt_d = 12'd0;
        end

        if (start_frame_s) begin
            timeout_err_d = 1'b0;
        end else if (timeout_hit_s) begin
            timeout_err_d = 1'b1;
        end else begin
            timeout_err_d = timeout_err_q;
        end

        if (start_frame_s) begin
            pixel_count_d = 17'd0;
        end else if (pix_ok_s && (pixel_count_q != 17'h1FFFF)) begin
            pixel_count_d = pixel_count_q + 17'd1;
        end else begin
            pixel_count_d = pixel_count_q;
        end

        if (in_phase_s) begin
            vga_x_d      = src_x_s;
            vga_y_d      = src_y_s;
            vga_colour_d = src_colour_s;
        end else begin
            vga_x_d      = vga_x_q;
            vga_y_d      = vga_y_q;
            vga_colour_d = vga_colour_q;
        end
        vga_write_d = pix_ok_s;
    end

    // Datapath registers.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            cnt_q         <= 12'd0;
            timeout_err_q <= 1'b0;
            pixel_count_q <= 17'd0;
            vga_x_q       <= 9'd0;
            vga_y_q       <= 8'd0;
            vga_colour_q  <= 6'd0;
            vga_write_q   <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            timeout_err_q <= timeout_err_d;
            pixel_count_q <= pixel_count_d;
            vga_x_q       <= vga_x_d;
            vga_y_q       <= vga_y_d;
            vga_colour_q  <= vga_colour_d;
            vga_write_q   <= vga_write_d;
        end
    end

    // Outputs decoded straight from the state register.
    always_comb begin
        bus.bg_draw    = (state_q == S_BG);
        bus.link_draw  = (state_q == S_LINK);
        bus.enemy_draw = (state_q == S_ENEMY);
        bus.busy       = (state_q != S_IDLE);
        bus.frame_done = (state_q == S_DONE);
    end

    assign bus.vga_x       = vga_x_q;
    assign bus.vga_y       = vga_y_q;
    assign bus.vga_colour  = vga_colour_q;
    assign bus.vga_write   = vga_write_q;
    assign bus.timeout_err = timeout_err_q;
    assign bus.pixel_count = pixel_count_q;

endmodule
